// File: rtl/qspi_pad_arbiter.sv
// Shares the QSPI flash pads between the SoC qspi0 master and an FPGA-side auxiliary master.
// Define QSPI_ARB_TIMEOUT_EN to build the MAX_HOLD forced release and the hold_timeout flag.
module qspi_pad_arbiter #(
    parameter int IDLE_MIN = 16,
    parameter int GUARD    = 4,
    parameter int MAX_HOLD = 65535
) (
    input  logic       clk_16M,
    input  logic       reset_periph,
    input  logic       soc_sck,
    input  logic       soc_cs,
    input  logic [3:0] soc_dq_o,
    input  logic [3:0] soc_dq_oe,
    output logic [3:0] soc_dq_i,
    input  logic       aux_req,
    output logic       aux_gnt,
    input  logic       aux_sck,
    input  logic       aux_cs,
    input  logic [3:0] aux_dq_o,
    input  logic [3:0] aux_dq_oe,
    output logic [3:0] aux_dq_i,
    output logic       pad_sck,
    output logic       pad_cs,
    output logic [3:0] pad_dq_o,
    output logic [3:0] pad_dq_oe,
    input  logic [3:0] pad_dq_i,
    output logic       conflict,
    input  logic       conflict_clr,
    output logic       hold_timeout
);
    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam int GW = $clog2(GUARD + 1);

    typedef enum logic [2:0] {SOC, WAIT_IDLE, GUARD_A, AUX, GUARD_S} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idle_cnt, idle_cnt_nx;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic          rearm;
    logic          timeout_hit;

`ifdef QSPI_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;

    // hold_cnt sits at 0 outside AUX, so it restarts on every entry.
    assign timeout_hit = (state == AUX) && aux_req && (hold_cnt == 16'(MAX_HOLD - 1));

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            hold_cnt <= (state == AUX) ? hold_cnt + 16'd1 : 16'd0;
            if (timeout_hit)
                hold_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            state    <= SOC;
            idle_cnt <= '0;
            gcnt     <= '0;
            rearm    <= 1'b1;
            conflict <= 1'b0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_cnt_nx;
            gcnt     <= gcnt_nx;
            // A forced release stays latched until A has let go of its request.
            if (!aux_req)
                rearm <= 1'b1;
            else if (timeout_hit)
                rearm <= 1'b0;
            if ((state == GUARD_A || state == AUX || state == GUARD_S) && !soc_cs)
                conflict <= 1'b1;
            else if (conflict_clr)
                conflict <= 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        gcnt_nx     = gcnt;
        case (state)
            SOC: begin
                if (aux_req && rearm) begin
                    state_nx    = WAIT_IDLE;
                    idle_cnt_nx = '0;
                end
            end
            WAIT_IDLE: begin
                if (!aux_req) begin
                    state_nx = SOC;
                end else if (!soc_cs) begin
                    idle_cnt_nx = '0;
                end else if (idle_cnt == IW'(IDLE_MIN - 1)) begin
                    state_nx = GUARD_A;
                    gcnt_nx  = '0;
                end else begin
                    idle_cnt_nx = idle_cnt + 1'b1;
                end
            end
            GUARD_A: begin
                if (!aux_req) begin
                    state_nx = GUARD_S;
                    gcnt_nx  = '0;
                end else if (gcnt == GW'(GUARD - 1)) begin
                    state_nx = AUX;
                end else begin
                    gcnt_nx = gcnt + 1'b1;
                end
            end
            AUX: begin
                if (!aux_req || timeout_hit) begin
                    state_nx = GUARD_S;
                    gcnt_nx  = '0;
                end
            end
            GUARD_S: begin
                if (gcnt == GW'(GUARD - 1))
                    state_nx = SOC;
                else
                    gcnt_nx = gcnt + 1'b1;
            end
            default: state_nx = SOC;
        endcase
    end

    assign aux_gnt = (state == AUX);

    // Zero-latency mux from registered state; guards park the pads deselected and undriven.
    always_comb begin
        pad_sck   = soc_sck;
        pad_cs    = soc_cs;
        pad_dq_o  = soc_dq_o;
        pad_dq_oe = soc_dq_oe;
        soc_dq_i  = pad_dq_i;
        aux_dq_i  = 4'hF;
        case (state)
            AUX: begin
                pad_sck   = aux_sck;
                pad_cs    = aux_cs;
                pad_dq_o  = aux_dq_o;
                pad_dq_oe = aux_dq_oe;
                soc_dq_i  = 4'hF;
                aux_dq_i  = pad_dq_i;
            end
            GUARD_A, GUARD_S: begin
                pad_sck   = 1'b0;
                pad_cs    = 1'b1;
                pad_dq_o  = 4'h0;
                pad_dq_oe = 4'h0;
                soc_dq_i  = 4'hF;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_qspi_pad_arbiter.sv
// Randomized bench for qspi_pad_arbiter against an ownership/timeline reference model.
module tb_qspi_pad_arbiter;
    localparam int IDLE_MIN = 16;
    localparam int GUARD    = 4;
    localparam int MAX_HOLD = 8;
`ifdef QSPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk_16M = 1'b0;
    logic reset_periph;
    logic soc_sck, soc_cs, aux_req, aux_sck, aux_cs, conflict_clr;
    logic [3:0] soc_dq_o, soc_dq_oe, aux_dq_o, aux_dq_oe, pad_dq_i;
    logic [3:0] soc_dq_i, aux_dq_i, pad_dq_o, pad_dq_oe;
    logic aux_gnt, pad_sck, pad_cs, conflict, hold_timeout;

    always #5 clk_16M = ~clk_16M;

    qspi_pad_arbiter #(.IDLE_MIN(IDLE_MIN), .GUARD(GUARD), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_16M(clk_16M), .reset_periph(reset_periph),
        .soc_sck(soc_sck), .soc_cs(soc_cs), .soc_dq_o(soc_dq_o), .soc_dq_oe(soc_dq_oe),
        .soc_dq_i(soc_dq_i), .aux_req(aux_req), .aux_gnt(aux_gnt),
        .aux_sck(aux_sck), .aux_cs(aux_cs), .aux_dq_o(aux_dq_o), .aux_dq_oe(aux_dq_oe),
        .aux_dq_i(aux_dq_i), .pad_sck(pad_sck), .pad_cs(pad_cs), .pad_dq_o(pad_dq_o),
        .pad_dq_oe(pad_dq_oe), .pad_dq_i(pad_dq_i), .conflict(conflict),
        .conflict_clr(conflict_clr), .hold_timeout(hold_timeout)
    );

    // Reference model: who owns the pads, how much guard time is left, how long S has been idle.
    bit m_owner_a, m_waiting, m_to_aux, m_rearm, m_conflict, m_timeout;
    int m_guard_left, m_idle_run, m_hold;
    int vectors = 0, errors = 0;

    task automatic model_reset();
        m_owner_a = 0; m_waiting = 0; m_to_aux = 0; m_rearm = 1;
        m_conflict = 0; m_timeout = 0; m_guard_left = 0; m_idle_run = 0; m_hold = 0;
    endtask

    task automatic model_step();
        bit busy;
        if (reset_periph) begin
            model_reset();
            return;
        end
        busy = (m_guard_left > 0) || m_owner_a;
        if (busy && !soc_cs) m_conflict = 1;
        else if (conflict_clr) m_conflict = 0;
        if (m_guard_left > 0) begin
            if (m_to_aux && !aux_req) begin
                m_guard_left = GUARD; m_to_aux = 0;
            end else if (m_guard_left == 1) begin
                m_guard_left = 0;
                if (m_to_aux) begin m_owner_a = 1; m_hold = 0; end
            end else m_guard_left--;
        end else if (m_owner_a) begin
            if (!aux_req) begin
                m_owner_a = 0; m_guard_left = GUARD; m_to_aux = 0;
            end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
                m_owner_a = 0; m_guard_left = GUARD; m_to_aux = 0;
                m_timeout = 1; m_rearm = 0;
            end else m_hold++;
        end else if (m_waiting) begin
            if (!aux_req) m_waiting = 0;
            else if (!soc_cs) m_idle_run = 0;
            else if (m_idle_run + 1 == IDLE_MIN) begin
                m_waiting = 0; m_guard_left = GUARD; m_to_aux = 1;
            end else m_idle_run++;
        end else if (aux_req && m_rearm) begin
            m_waiting = 1; m_idle_run = 0;
        end
        if (!aux_req) m_rearm = 1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check();
        logic e_sck, e_cs;
        logic [3:0] e_o, e_oe, e_si, e_ai;
        vectors++;
        if (m_guard_left > 0) begin
            e_sck = 0; e_cs = 1; e_o = 0; e_oe = 0; e_si = 4'hF; e_ai = 4'hF;
        end else if (m_owner_a) begin
            e_sck = aux_sck; e_cs = aux_cs; e_o = aux_dq_o; e_oe = aux_dq_oe;
            e_si = 4'hF; e_ai = pad_dq_i;
        end else begin
            e_sck = soc_sck; e_cs = soc_cs; e_o = soc_dq_o; e_oe = soc_dq_oe;
            e_si = pad_dq_i; e_ai = 4'hF;
        end
        chk("pad_sck", {3'b0, pad_sck}, {3'b0, e_sck});
        chk("pad_cs", {3'b0, pad_cs}, {3'b0, e_cs});
        chk("pad_dq_o", pad_dq_o, e_o);
        chk("pad_dq_oe", pad_dq_oe, e_oe);
        chk("soc_dq_i", soc_dq_i, e_si);
        chk("aux_dq_i", aux_dq_i, e_ai);
        chk("aux_gnt", {3'b0, aux_gnt}, {3'b0, m_owner_a});
        chk("conflict", {3'b0, conflict}, {3'b0, m_conflict});
        chk("hold_timeout", {3'b0, hold_timeout}, {3'b0, m_timeout});
    endtask

    task automatic rand_data();
        soc_dq_o = 4'($urandom); aux_dq_o = 4'($urandom);
        aux_dq_oe = 4'($urandom); pad_dq_i = 4'($urandom);
        soc_sck = 1'($urandom); aux_sck = 1'($urandom);
    endtask

    task automatic tick();
        rand_data();
        #1 check();
        @(posedge clk_16M);
        model_step();
        #1;
    endtask

    initial begin
        reset_periph = 1; soc_cs = 1; aux_req = 0; aux_cs = 1; conflict_clr = 0;
        soc_dq_oe = 4'h1;
        rand_data();
        @(posedge clk_16M);
        model_step();
        #1;
        tick();
        reset_periph = 0;

        // S alone, toggling cs/sck.
        for (int i = 0; i < 20; i++) begin
            soc_cs = 1'($urandom);
            tick();
        end

        // Clean handover: grant exactly 1+IDLE_MIN+GUARD cycles after the request.
        soc_cs = 1; tick(); tick();
        aux_req = 1;
        for (int k = 0; k <= 25; k++) begin
            assert (aux_gnt === (k >= 1 + IDLE_MIN + GUARD)) else begin
                errors++;
                $error("FAIL grant_latency cycle=%0d observed=%b expected=%b", k, aux_gnt,
                       k >= 1 + IDLE_MIN + GUARD);
            end
            aux_cs = 1'($urandom);
            tick();
        end

        // SoC cs activity while A owns; clear colliding with a fresh set.
        soc_cs = 0; tick();
        soc_cs = 1; conflict_clr = 1; tick();
        conflict_clr = 0; tick();
        soc_cs = 0; conflict_clr = 1; tick();
        soc_cs = 1; conflict_clr = 0; tick();
        conflict_clr = 1; tick();
        conflict_clr = 0;

        // Release, then re-request with a cs glitch on the last idle cycle.
        aux_cs = 1; aux_req = 0;
        for (int i = 0; i < 8; i++) tick();
        aux_req = 1;
        for (int k = 0; k < 45; k++) begin
            soc_cs = (k != IDLE_MIN);
            tick();
        end

        // Hold past MAX_HOLD, then drop for one cycle and re-request.
        for (int i = 0; i < 20; i++) tick();
        aux_req = 0; tick();
        aux_req = 1;
        for (int i = 0; i < 30; i++) tick();

        // Reset while A is granted.
        aux_req = 0;
        for (int i = 0; i < 6; i++) tick();
        aux_req = 1;
        for (int i = 0; i < 22; i++) tick();
        soc_cs = 0; tick();
        soc_cs = 1; reset_periph = 1; tick();
        reset_periph = 0; tick();
        aux_req = 0; tick();

        // Free-running random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0) aux_req = ~aux_req;
            soc_cs = ($urandom_range(31) != 0);
            conflict_clr = ($urandom_range(7) == 0);
            soc_dq_oe = 4'($urandom);
            aux_cs = 1'($urandom);
            if ($urandom_range(299) == 0) reset_periph = 1;
            tick();
            reset_periph = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
